// File: rtl/sobel_window_sequencer.sv
// Sobel window sequencer: turns a raster pixel stream into 3x3 neighbourhoods
// for the gradient datapath, using two ping-pong line buffers.
// Optional feature macro: SOBEL_WIN_COUNT_EN adds the win_count output.
module sobel_window_sequencer #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned PIX_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic [PIX_W-1:0]      pix_in,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic [8:0][PIX_W-1:0] window_buf,
  output logic                  window_valid,
  input  logic                  window_ready,
  output logic [15:0]           win_row,
  output logic [15:0]           win_col,
  output logic                  frame_done
`ifdef SOBEL_WIN_COUNT_EN
  ,
  output logic [31:0]           win_count
`endif
);

  localparam int unsigned AW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [15:0] LAST_COL = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] LAST_ROW = 16'(IMG_HEIGHT - 1);

  // Reject geometries the 16-bit position counters or the 3x3 window cannot handle
  if (IMG_WIDTH < 3 || IMG_WIDTH > 65535 || IMG_HEIGHT < 3 || IMG_HEIGHT > 65535) begin : g_bad_cfg
    $error("sobel_window_sequencer: IMG_WIDTH/IMG_HEIGHT must be in 3..65535");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, next_state;

  logic [15:0]           row;
  logic [15:0]           col;
  logic                  sel;      // 0: line_a holds row r-2, 1: line_b holds row r-2
  logic                  tail;     // last pixel of the frame has been taken
  logic [PIX_W-1:0]      line_a [IMG_WIDTH];
  logic [PIX_W-1:0]      line_b [IMG_WIDTH];
  logic [2:0][PIX_W-1:0] col_m2;   // column c-2: [0]=row r-2, [1]=row r-1, [2]=row r
  logic [2:0][PIX_W-1:0] col_m1;   // column c-1
  logic [2:0][PIX_W-1:0] col_new;  // column c being accepted now
  logic [AW-1:0]         addr;
  logic [PIX_W-1:0]      rd_a;
  logic [PIX_W-1:0]      rd_b;
  logic                  accept;
  logic                  handshake;
  logic                  wrap;
  logic                  emit;
  logic                  last_pix;
  logic                  last_hs;

  assign pix_ready = ((state == FILL) || (state == RUN)) && !tail &&
                     (!window_valid || window_ready);
  assign accept    = pix_valid && pix_ready;
  assign handshake = window_valid && window_ready;
  assign wrap      = (col == LAST_COL);
  assign emit      = accept && (row >= 16'd2) && (col >= 16'd2);
  assign last_pix  = (row == LAST_ROW) && wrap;
  assign last_hs   = (state == RUN) && tail && handshake;
  assign addr      = col[AW-1:0];
  assign rd_a      = line_a[addr];
  assign rd_b      = line_b[addr];
  assign col_new   = {pix_in, (sel ? rd_a : rd_b), (sel ? rd_b : rd_a)};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; frame_start restarts from any state
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (frame_start) next_state = FILL;
      FILL: begin
        if (frame_start)                                      next_state = FILL;
        else if (accept && (row == 16'd2) && (col == 16'd2))  next_state = RUN;
      end
      RUN: begin
        if (frame_start)  next_state = FILL;
        else if (last_hs) next_state = DONE;
      end
      DONE:    next_state = frame_start ? FILL : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Line buffers: the row r-2 slot is read and then overwritten with row r
  always_ff @(posedge clk) begin
    if (accept && !frame_start) begin
      if (sel) line_b[addr] <= pix_in;
      else     line_a[addr] <= pix_in;
    end
  end

  // Position counters, column shift registers and window presentation
  always_ff @(posedge clk) begin
    if (reset) begin
      row          <= '0;
      col          <= '0;
      sel          <= 1'b0;
      tail         <= 1'b0;
      col_m2       <= '0;
      col_m1       <= '0;
      window_buf   <= '0;
      window_valid <= 1'b0;
      win_row      <= '0;
      win_col      <= '0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= (next_state == DONE);
      if (frame_start) begin
        row          <= '0;
        col          <= '0;
        sel          <= 1'b0;
        tail         <= 1'b0;
        window_valid <= 1'b0;
      end else begin
        if (accept) begin
          col_m2 <= col_m1;
          col_m1 <= col_new;
          if (wrap) begin
            col <= '0;
            row <= row + 16'd1;
            sel <= ~sel;
          end else begin
            col <= col + 16'd1;
          end
          if (last_pix) tail <= 1'b1;
        end
        if (emit) begin
          window_valid <= 1'b1;
          win_row      <= row - 16'd1;
          win_col      <= col - 16'd1;
          for (int i = 0; i < 3; i++) begin
            window_buf[3*i]   <= col_m2[i];
            window_buf[3*i+1] <= col_m1[i];
            window_buf[3*i+2] <= col_new[i];
          end
        end else if (handshake) begin
          window_valid <= 1'b0;
        end
      end
    end
  end

`ifdef SOBEL_WIN_COUNT_EN
  // Window handshakes in the current frame; holds after frame_done
  always_ff @(posedge clk) begin
    if (reset || frame_start) win_count <= '0;
    else if (handshake)       win_count <= win_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_sobel_window_sequencer.sv
// Self-checking bench for sobel_window_sequencer on a 5x4 frame.
module tb_sobel_window_sequencer;

  localparam int W = 5;
  localparam int H = 4;

  logic            clk;
  logic            reset;
  logic            frame_start;
  logic [7:0]      pix_in;
  logic            pix_valid;
  logic            pix_ready;
  logic [8:0][7:0] window_buf;
  logic            window_valid;
  logic            window_ready;
  logic [15:0]     win_row;
  logic [15:0]     win_col;
  logic            frame_done;
`ifdef SOBEL_WIN_COUNT_EN
  logic [31:0]     win_count;
`endif

  sobel_window_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .window_buf(window_buf), .window_valid(window_valid), .window_ready(window_ready),
    .win_row(win_row), .win_col(win_col), .frame_done(frame_done)
`ifdef SOBEL_WIN_COUNT_EN
    , .win_count(win_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     row;
    logic [15:0]     col;
    logic [8:0][7:0] wbuf;
  } win_t;

  typedef struct {
    int mode;          // 0: r*10+c, 1: 40*r ramp, 2: hashed values
    int stall;         // window_ready low cycles at first window
    int abort_after;   // restart the frame after this many pixels (0 = never)
    bit rnd;           // random pix_valid / window_ready
    int exp_cycles;    // feed cycles for the full frame (-1 = not checked)
    int exp_win;
    int exp_done;
  } vec_t;

  win_t  sb[$];
  vec_t  vecs[5];
  int    n_pass = 0;
  int    n_total = 0;
  int    win_seen = 0;
  int    done_seen = 0;
  int    cur_mode = 0;
  bit    prev_stall = 1'b0;
  bit    prev_hs = 1'b0;
  logic [47:0] snap;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [7:0] pix_val(input int mode, input int r, input int c);
    case (mode)
      0:       return 8'(r * 10 + c);
      1:       return 8'(40 * r);
      default: return 8'((r * 37 + c * 11) ^ 90);
    endcase
  endfunction

  function automatic win_t exp_win(input int mode, input int r, input int c);
    win_t w;
    w.row = 16'(r - 1);
    w.col = 16'(c - 1);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w.wbuf[3*i+j] = pix_val(mode, r - 2 + i, c - 2 + j);
    return w;
  endfunction

  // Monitor: handshakes and stall stability are judged mid-cycle
  always @(negedge clk) begin
    if (prev_stall) begin
      check("stall_valid_held", 128'(window_valid), 128'(1));
      check("stall_window_stable", 128'({win_row, win_col, window_buf[1:0]}), 128'(snap));
    end
    if (window_valid && !window_ready && !frame_start && !reset) begin
      check("stall_pix_ready", 128'(pix_ready), 128'(0));
      snap = {win_row, win_col, window_buf[1:0]};
      prev_stall = 1'b1;
    end else begin
      prev_stall = 1'b0;
    end
    if (frame_done) begin
      done_seen++;
      check("done_after_last_hs", 128'(prev_hs && (sb.size() == 0)), 128'(1));
    end
    prev_hs = 1'b0;
    if (window_valid && window_ready) begin
      check("window_expected", 128'(sb.size() > 0), 128'(1));
      if (sb.size() > 0) begin
        win_t e;
        e = sb.pop_front();
        check("win_row", 128'(win_row), 128'(e.row));
        check("win_col", 128'(win_col), 128'(e.col));
        check("window_buf", 128'(window_buf), 128'(e.wbuf));
      end
      if (cur_mode == 1) begin
        int gy;
        gy = (int'(window_buf[6]) + 2 * int'(window_buf[7]) + int'(window_buf[8])) -
             (int'(window_buf[0]) + 2 * int'(window_buf[1]) + int'(window_buf[2]));
        if (gy < 0) gy = -gy;
        check("abs_gy", 128'(gy), 128'(320));
      end
      win_seen++;
      prev_hs = 1'b1;
    end
  end

  task automatic run_frame(input vec_t v);
    int idx, cycles, stall, ab, r, c;
    bit acc;
    cur_mode  = v.mode;
    sb.delete();
    win_seen  = 0;
    done_seen = 0;
    pix_valid = 1'b0;
    window_ready = 1'b1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    idx = 0; cycles = 0; stall = v.stall; ab = v.abort_after;
    while (idx < W * H && cycles < 400) begin
      r = idx / W;
      c = idx % W;
      pix_in    = pix_val(v.mode, r, c);
      pix_valid = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall > 0 && window_valid) begin
        window_ready = 1'b0;
        stall--;
      end else begin
        window_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge clk);
      acc = pix_valid && pix_ready;
      if (acc && r >= 2 && c >= 2) sb.push_back(exp_win(v.mode, r, c));
      @(posedge clk); #1;
      if (acc) idx++;
      cycles++;
      if (ab > 0 && idx == ab) begin
        pix_valid = 1'b0;
        window_ready = 1'b0;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        window_ready = 1'b1;
        sb.delete();
        win_seen = 0;
        idx = 0; cycles = 0; ab = 0;
      end
    end
    check("pixels_accepted", 128'(idx), 128'(W * H));
    if (v.exp_cycles >= 0) check("feed_cycles", 128'(cycles), 128'(v.exp_cycles));
    // Extra pixels after the last one must never be taken
    pix_valid = 1'b1;
    pix_in = 8'hEE;
    window_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("tail_pix_ready", 128'(pix_ready), 128'(0));
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    check("window_count", 128'(win_seen), 128'(v.exp_win));
    check("frame_done_count", 128'(done_seen), 128'(v.exp_done));
    check("scoreboard_empty", 128'(sb.size()), 128'(0));
`ifdef SOBEL_WIN_COUNT_EN
    check("win_count", 128'(win_count), 128'(v.exp_win));
`endif
  endtask

  initial begin
    vecs[0] = '{mode: 0, stall: 0, abort_after: 0,  rnd: 1'b0, exp_cycles: 20, exp_win: 6, exp_done: 1};
    vecs[1] = '{mode: 0, stall: 5, abort_after: 0,  rnd: 1'b0, exp_cycles: 25, exp_win: 6, exp_done: 1};
    vecs[2] = '{mode: 1, stall: 0, abort_after: 0,  rnd: 1'b0, exp_cycles: 20, exp_win: 6, exp_done: 1};
    vecs[3] = '{mode: 0, stall: 0, abort_after: 13, rnd: 1'b0, exp_cycles: 20, exp_win: 6, exp_done: 1};
    vecs[4] = '{mode: 2, stall: 0, abort_after: 0,  rnd: 1'b1, exp_cycles: -1, exp_win: 6, exp_done: 1};

    reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_in = '0; window_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    pix_valid = 1'b1;
    @(negedge clk);
    check("rst_pix_ready", 128'(pix_ready), 128'(0));
    check("rst_window_valid", 128'(window_valid), 128'(0));
    check("rst_window_buf", 128'(window_buf), 128'(0));
    check("rst_win_pos", 128'({win_row, win_col}), 128'(0));
    check("rst_frame_done", 128'(frame_done), 128'(0));
    @(posedge clk); #1;
    pix_valid = 1'b0;

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // Reset in the middle of RUN, together with frame_start: reset wins
    cur_mode = 0;
    sb.delete();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    for (int k = 0; k < 14; k++) begin
      pix_in = pix_val(0, k / W, k % W);
      pix_valid = 1'b1;
      window_ready = 1'b1;
      @(negedge clk);
      if (pix_ready && (k / W) >= 2 && (k % W) >= 2) sb.push_back(exp_win(0, k / W, k % W));
      @(posedge clk); #1;
    end
    reset = 1'b1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    frame_start = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_window_valid", 128'(window_valid), 128'(0));
    check("midrst_window_buf", 128'(window_buf), 128'(0));
    check("midrst_win_pos", 128'({win_row, win_col}), 128'(0));
    check("midrst_frame_done", 128'(frame_done), 128'(0));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("idle_pix_ready", 128'(pix_ready), 128'(0));
      check("idle_window_valid", 128'(window_valid), 128'(0));
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    run_frame(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
